// File: rtl/playbus_seq_if.sv
// rtl/playbus_seq_if.sv - transfer request/bus/status bundle for playbus_seq
interface playbus_seq_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic                  start;
  logic [1:0]            src;
  logic [1:0]            dst;
  logic [AW-1:0]         addr_in;
  logic                  inc;
  logic [DW-1:0]         sw;
  logic [DW-1:0]         rom_data;
  logic [AW-1:0]         rom_addr;
  logic                  rom_oe;
  logic [DW-1:0]         bus;
  logic [DW-1:0]         led;
  logic [7*(DW/4)-1:0]   disp;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, src, dst, addr_in, inc, sw, rom_data,
    input  rom_addr, rom_oe, bus, led, disp, busy, done, err
  );

  modport slave (
    input  start, src, dst, addr_in, inc, sw, rom_data,
    output rom_addr, rom_oe, bus, led, disp, busy, done, err
  );
endinterface

// File: rtl/playbus_seq.sv
// rtl/playbus_seq.sv - sequenced source->bus->destination transfer engine with RAM, LED latch and seven-seg
module playbus_seq #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int ROM_WAIT = 1
) (
  input  logic          clk,
  input  logic          reset,
  playbus_seq_if.slave  pb
);
  localparam int NDISP = DW / 4;
  localparam int CW    = (ROM_WAIT > 1) ? $clog2(ROM_WAIT + 1) : 1;

  localparam logic [1:0] SRC_SW  = 2'd0;
  localparam logic [1:0] SRC_ROM = 2'd1;
  localparam logic [1:0] SRC_RAM = 2'd2;
  localparam logic [1:0] SRC_LED = 2'd3;

  localparam logic [1:0] DST_NONE = 2'd0;
  localparam logic [1:0] DST_RAM  = 2'd1;
  localparam logic [1:0] DST_LED  = 2'd2;
  localparam logic [1:0] DST_ADDR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   addr_q;
  logic [1:0]      src_q;
  logic [1:0]      dst_q;
  logic            inc_q;
  logic [CW-1:0]   wcnt;
  logic [DW-1:0]   led_q;
  logic            err_q;
  logic [DW-1:0]   mem [2**AW];

  logic            conflict;
  logic            last_drive;
  logic            write_now;
  logic [DW-1:0]   bus_v;

  assign conflict   = ((pb.src == SRC_RAM) && (pb.dst == DST_RAM)) ||
                      ((pb.src == SRC_LED) && (pb.dst == DST_LED));
  assign last_drive = (src_q != SRC_ROM) || (wcnt == CW'(ROM_WAIT - 1));
  assign write_now  = (state == S_DRIVE) && last_drive;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (pb.start && !conflict) state_nx = S_DRIVE;
      S_DRIVE: if (last_drive)            state_nx = S_DONE;
      S_DONE:                             state_nx = S_IDLE;
      default:                            state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus_v     = '0;
    pb.busy   = 1'b0;
    pb.done   = 1'b0;
    pb.rom_oe = 1'b0;
    case (state)
      S_DRIVE: begin
        pb.busy = 1'b1;
        case (src_q)
          SRC_SW:  bus_v = pb.sw;
          SRC_ROM: begin
            bus_v     = pb.rom_data;
            pb.rom_oe = 1'b1;
          end
          SRC_RAM: bus_v = mem[addr_q];
          default: bus_v = led_q;
        endcase
      end
      S_DONE: begin
        pb.busy = 1'b1;
        pb.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      src_q  <= SRC_SW;
      dst_q  <= DST_NONE;
      inc_q  <= 1'b0;
      wcnt   <= '0;
      led_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: if (pb.start) begin
          addr_q <= pb.addr_in;
          src_q  <= pb.src;
          dst_q  <= pb.dst;
          inc_q  <= pb.inc;
          wcnt   <= '0;
          err_q  <= conflict;
        end
        S_DRIVE: begin
          wcnt <= wcnt + 1'b1;
          if (last_drive) begin
            if (dst_q == DST_LED)  led_q  <= bus_v;
            if (dst_q == DST_ADDR) addr_q <= bus_v[AW-1:0];
          end
        end
        S_DONE: if (inc_q && (dst_q != DST_ADDR)) addr_q <= addr_q + 1'b1;
        default: ;
      endcase
    end
  end

  // RAM has no reset; a reset edge still blocks a pending write
  always_ff @(posedge clk) begin
    if (!reset && write_now && (dst_q == DST_RAM)) mem[addr_q] <= bus_v;
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b0100111;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  for (genvar i = 0; i < NDISP; i++) begin : g_disp
    assign pb.disp[7*i +: 7] = seg7(led_q[4*i +: 4]);
  end

  assign pb.bus      = bus_v;
  assign pb.led      = led_q;
  assign pb.rom_addr = addr_q;
  assign pb.err      = err_q;
endmodule
